// File: rtl/gpr_file_mp_pkg.sv
// Shared types and default sizes for the multi-read-port register file.
// Imported by the top level and the storage bank.
package gpr_file_mp_pkg;

   localparam int GPR_XLEN = 32;
   localparam int GPR_NREG = 32;
   localparam int GPR_AW   = 5;
   localparam int GPR_NRP  = 2;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } gpr_state_e;

   function automatic logic addr_in_range(input int addr, input int nreg);
      return addr < nreg;
   endfunction

endpackage

// File: rtl/gpr_file_mp_bank.sv
// One register bank: NREG x XLEN array with one write port and one
// synchronous read-first read port.
module gpr_file_mp_bank #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr,
   output logic [XLEN-1:0] rdata
);

   logic [XLEN-1:0] mem [NREG];
   logic [XLEN-1:0] rdata_reg;

   // Read and write share the edge; the read returns pre-write contents.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata_reg <= mem[raddr];
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/gpr_file_mp.sv
// Multi-read-port GPR file: replicated banks, post-reset clear sequencer,
// write-first bypass and optional hard-wired zero register.
module gpr_file_mp
   import gpr_file_mp_pkg::*;
#(
   parameter int XLEN     = GPR_XLEN,
   parameter int NREG     = GPR_NREG,
   parameter int AW       = GPR_AW,
   parameter int NRP      = GPR_NRP,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [AW-1:0]       rd,
   input  logic [XLEN-1:0]     di,
   input  logic [NRP*AW-1:0]   ra,
   output logic [NRP*XLEN-1:0] qa,
   output logic                ready
);

   gpr_state_e      state_reg, state_next;
   logic [AW:0]     clr_idx_reg, clr_idx_next;
   logic            clr_last;
   logic            clearing;
   logic            wr_ok;
   logic            bank_we;
   logic [AW-1:0]   bank_waddr;
   logic [XLEN-1:0] bank_wdata;
   logic [XLEN-1:0] di_reg;

   assign clr_last = (clr_idx_reg == (AW+1)'(NREG - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_CLEAR;
         clr_idx_reg <= '0;
      end else begin
         state_reg   <= state_next;
         clr_idx_reg <= clr_idx_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      clr_idx_next = clr_idx_reg;
      case (state_reg)
         ST_CLEAR: begin
            clr_idx_next = clr_idx_reg + 1'b1;
            if (clr_last) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN:  state_next = ST_RUN;
         default: state_next = ST_CLEAR;
      endcase
   end

   always_comb begin
      ready    = (state_reg == ST_RUN);
      clearing = (state_reg == ST_CLEAR) && !rst;
   end

   // External writes only land in RUN, in range, and never on a hard-wired x0.
   assign wr_ok = ready && !rst && we && addr_in_range(32'(rd), NREG)
                  && !((ZERO_REG != 0) && (rd == '0));

   assign bank_we    = clearing || wr_ok;
   assign bank_waddr = clearing ? clr_idx_reg[AW-1:0] : rd;
   assign bank_wdata = clearing ? '0 : di;

   always_ff @(posedge clk) begin
      di_reg <= di;
   end

   generate
      for (genvar gi = 0; gi < NRP; gi++) begin : g_port
         logic [AW-1:0]   ra_p;
         logic [XLEN-1:0] bank_q;
         logic            force_zero_reg;
         logic            bypass_reg;

         assign ra_p = ra[gi*AW +: AW];

         gpr_file_mp_bank #(
            .XLEN (XLEN),
            .NREG (NREG),
            .AW   (AW)
         ) u_bank (
            .clk   (clk),
            .we    (bank_we),
            .waddr (bank_waddr),
            .wdata (bank_wdata),
            .raddr (ra_p),
            .rdata (bank_q)
         );

         // Zero forcing takes priority over bypass so x0 and clear always read 0.
         always_ff @(posedge clk) begin
            if (rst) begin
               force_zero_reg <= 1'b1;
               bypass_reg     <= 1'b0;
            end else begin
               force_zero_reg <= !ready || !addr_in_range(32'(ra_p), NREG)
                                 || ((ZERO_REG != 0) && (ra_p == '0));
               bypass_reg     <= (BYPASS != 0) && wr_ok && (rd == ra_p);
            end
         end

         assign qa[gi*XLEN +: XLEN] = force_zero_reg ? '0 :
                                      bypass_reg     ? di_reg : bank_q;
      end
   endgenerate

endmodule

// File: tb/tb_gpr_file_mp.sv
// Randomised scoreboard bench for gpr_file_mp against a behavioural model.
module tb_gpr_file_mp;

   localparam int XLEN     = 32;
   localparam int NREG     = 32;
   localparam int AW       = 5;
   localparam int NRP      = 2;
   localparam int ZERO_REG = 1;
   localparam int BYPASS   = 1;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                we  = 1'b0;
   logic [AW-1:0]       rd  = '0;
   logic [XLEN-1:0]     di  = '0;
   logic [NRP*AW-1:0]   ra  = '0;
   logic [NRP*XLEN-1:0] qa;
   logic                ready;

   always #5 clk = ~clk;

   gpr_file_mp #(
      .XLEN     (XLEN),
      .NREG     (NREG),
      .AW       (AW),
      .NRP      (NRP),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .rd    (rd),
      .di    (di),
      .ra    (ra),
      .qa    (qa),
      .ready (ready)
   );

   typedef struct packed {
      logic                rdy;
      logic [NRP*XLEN-1:0] qa;
   } exp_t;

   exp_t            exp_q[$];
   logic [XLEN-1:0] model_mem[NREG];
   int              clear_rem = 0;
   bit              started = 0;
   int              n_checks = 0;
   int              n_pass = 0;

   task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Drives one cycle of inputs and records what the DUT must show after that edge.
   task automatic step(input bit r, input bit w, input int wa, input logic [XLEN-1:0] wd,
                       input int a0, input int a1);
      int   ra_i[NRP];
      exp_t e;
      bit   legal;
      @(negedge clk);
      rst = r;
      we  = w;
      rd  = AW'(wa);
      di  = wd;
      ra  = {AW'(a1), AW'(a0)};
      ra_i[0] = a0;
      ra_i[1] = a1;
      if (r) started = 1;
      legal = w && (wa < NREG) && !((ZERO_REG != 0) && (wa == 0));
      e.qa = '0;
      if (r)                  e.rdy = 1'b0;
      else if (clear_rem > 0) e.rdy = (clear_rem == 1);
      else begin
         e.rdy = 1'b1;
         for (int p = 0; p < NRP; p++) begin
            if (ra_i[p] >= NREG || ((ZERO_REG != 0) && ra_i[p] == 0))
               e.qa[p*XLEN +: XLEN] = '0;
            else if ((BYPASS != 0) && legal && wa == ra_i[p])
               e.qa[p*XLEN +: XLEN] = wd;
            else
               e.qa[p*XLEN +: XLEN] = model_mem[ra_i[p]];
         end
      end
      if (r) begin
         clear_rem = NREG;
         for (int i = 0; i < NREG; i++) model_mem[i] = '0;
      end else if (clear_rem > 0) begin
         clear_rem--;
      end else if (legal) begin
         model_mem[wa] = wd;
      end
      if (started) exp_q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ready", XLEN'(ready), XLEN'(e.rdy));
            for (int p = 0; p < NRP; p++)
               chk($sformatf("qa%0d", p), qa[p*XLEN +: XLEN], e.qa[p*XLEN +: XLEN]);
         end
      end
   end

   initial begin : driver
      int wa, a0, a1;
      step(1, 0, 0, '0, 0, 0);
      // Reset mid-clear, with writes attempted during clear.
      for (int i = 0; i < 10; i++) step(0, 1, 3, 32'hAA, i, 3);
      step(1, 0, 0, '0, 0, 0);
      for (int i = 0; i < NREG + 2; i++) step(0, 1, 3, 32'hAA, 3, i % NREG);
      for (int i = 0; i < NREG; i++) step(0, 0, 0, '0, i, NREG - 1 - i);
      // Write then read, bypass, zero register.
      step(0, 1, 5, 32'hDEADBEEF, 0, 0);
      step(0, 0, 0, '0, 5, 5);
      step(0, 1, 7, 32'h12345678, 7, 5);
      step(0, 0, 0, '0, 7, 7);
      step(0, 1, 0, 32'hFFFFFFFF, 0, 7);
      step(0, 0, 0, '0, 0, 5);
      // Randomised traffic with occasional resets and bypass-biased addresses.
      for (int i = 0; i < 3000; i++) begin
         wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, NREG - 1));
         a0 = ($urandom_range(0, 2) == 0) ? wa : int'($urandom_range(0, NREG - 1));
         a1 = ($urandom_range(0, 3) == 0) ? a0 : int'($urandom_range(0, NREG - 1));
         step(($urandom_range(0, 599) == 0), $urandom_range(0, 1) == 1, wa, $urandom, a0, a1);
      end
      for (int i = 0; i < NREG + 2; i++) step(0, 0, 0, '0, i % NREG, (i + 1) % NREG);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0)
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      else
         n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
